seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller: the successor of the fixed 4-digit display driver. It supports any digit count, a configurable refresh rate, per-digit decimal points, leading-zero blanking, PWM brightness and tear-free double-buffered updates. It sits between the calculator datapath and the board's SEG/DP/AN pins, and replaces the separate clock-divider, formatter and scan-register blocks.

---
 rtl/seg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Scans NUM_DIGITS digits, each for 2^DIV_BITS clocks. Display data is
// double-buffered so that a frame never shows a mix of old and new values.
// Per-digit decimal points, leading-zero blanking and PWM brightness are
// supported. All outputs are registered.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_BITS    = 10,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                      clk_pi,
    input  logic                      rst_pi,
    input  logic [4*NUM_DIGITS-1:0]   num_pi,
    input  logic [NUM_DIGITS-1:0]     dp_pi,
    input  logic                      load_pi,
    input  logic                      blank_lz_pi,
    input  logic [BRIGHT_BITS-1:0]    bright_pi,
    output logic [6:0]                seg_po,
    output logic                      dp_po,
    output logic [NUM_DIGITS-1:0]     an_po,
    output logic                      frame_po
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_BITS-1:0]     div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow_num;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] active_num;
    logic [NUM_DIGITS-1:0]   active_dp;

    logic                    tick;
    logic                    frame_wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    lz_blank;
    logic                    all_zero;
    logic [BRIGHT_BITS-1:0]  phase;
    logic                    lit;
    logic [6:0]              next_seg;
    logic                    next_dp;
    logic [NUM_DIGITS-1:0]   next_an;
    logic                    next_frame;

    // Active-low segment pattern (a..g on bits 0..6) for a hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h18;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // A tick ends a digit slot; a tick on the last digit ends the frame.
    always_comb begin
        tick       = &div_cnt;
        frame_wrap = tick && (digit_idx == LAST_IDX);
    end

    // Slot divider and digit scan position.
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (tick) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Shadow/active double buffer; the active copy only changes at a frame wrap.
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            shadow_num <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            active_num <= '0;
            active_dp  <= '0;
        end else if (load_pi && frame_wrap) begin
            shadow_num <= num_pi;
            shadow_dp  <= dp_pi;
            active_num <= num_pi;
            active_dp  <= dp_pi;
            pending    <= 1'b0;
        end else if (load_pi) begin
            shadow_num <= num_pi;
            shadow_dp  <= dp_pi;
            pending    <= 1'b1;
        end else if (frame_wrap && pending) begin
            active_num <= shadow_num;
            active_dp  <= shadow_dp;
            pending    <= 1'b0;
        end
    end

    // Select the current digit, decide blanking/PWM and form the next outputs.
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        lz_blank = 1'b0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (active_num[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                cur_nib  = active_num[4*i +: 4];
                cur_dp   = active_dp[i];
                lz_blank = (i != 0) && all_zero;
            end
        end
        phase      = div_cnt[DIV_BITS-1 -: BRIGHT_BITS];
        lit        = (phase <= bright_pi) && !(blank_lz_pi && lz_blank);
        next_frame = (digit_idx == '0) && (div_cnt == '0);
        if (lit) begin
            next_an  = ~(NUM_DIGITS'(1) << digit_idx);
            next_seg = glyph(cur_nib);
            next_dp  = ~cur_dp;
        end else begin
            next_an  = {NUM_DIGITS{1'b1}};
            next_seg = 7'h7F;
            next_dp  = 1'b1;
        end
    end

    // Output registers; everything dark while in reset.
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            seg_po   <= 7'h7F;
            dp_po    <= 1'b1;
            an_po    <= {NUM_DIGITS{1'b1}};
            frame_po <= 1'b0;
        end else begin
            seg_po   <= next_seg;
            dp_po    <= next_dp;
            an_po    <= next_an;
            frame_po <= next_frame;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (4 digits,
// 16-cycle slots, 2-bit brightness). A cycle-count based model predicts
// every output cycle; directed literal checks pin the model.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DB = 4;
    localparam int BB = 2;
    localparam int SLOT = 1 << DB;
    localparam int FRAME = ND * SLOT;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          clk;
    logic          rst;
    logic [15:0]   num;
    logic [3:0]    dp_in;
    logic          load;
    logic          blank;
    logic [BB-1:0] bright;
    logic [6:0]    seg;
    logic          dp_out;
    logic [3:0]    an;
    logic          frame;

    int checks;
    int failures;

    // Model state: cycle count since reset release and the two buffers.
    int          m_cnt;
    logic [19:0] m_active;
    logic [19:0] m_shadow;
    logic        m_pending;
    logic [12:0] m_exp;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV_BITS(DB), .BRIGHT_BITS(BB)) dut (
        .clk_pi      (clk),
        .rst_pi      (rst),
        .num_pi      (num),
        .dp_pi       (dp_in),
        .load_pi     (load),
        .blank_lz_pi (blank),
        .bright_pi   (bright),
        .seg_po      (seg),
        .dp_po       (dp_out),
        .an_po       (an),
        .frame_po    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {frame, an, seg, dp} for output cycle c from the display rules.
    function automatic logic [12:0] modelOut(input int c, input logic [19:0] act,
                                             input logic bl, input logic [BB-1:0] br);
        int          d;
        int          phase;
        logic [15:0] upper;
        logic        f;
        logic [3:0]  a;
        logic [6:0]  s;
        logic        p;
        d     = (c / SLOT) % ND;
        phase = (c % SLOT) / (SLOT >> BB);
        f     = ((c % FRAME) == 0);
        upper = act[15:0] >> (4 * d);
        if (phase > int'(br) || (bl && d != 0 && upper == 16'h0)) begin
            a = 4'hF;
            s = 7'h7F;
            p = 1'b1;
        end else begin
            a = ~(4'b0001 << d);
            s = GLYPH[upper[3:0]];
            p = ~act[16 + d];
        end
        return {f, a, s, p};
    endfunction

    // Reference model: predicts the next output cycle and tracks buffering.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt     <= 0;
            m_active  <= '0;
            m_shadow  <= '0;
            m_pending <= 1'b0;
            m_exp     <= {1'b0, 4'hF, 7'h7F, 1'b1};
        end else begin
            m_exp <= modelOut(m_cnt, m_active, blank, bright);
            if (load && (m_cnt % FRAME) == FRAME - 1) begin
                m_active  <= {dp_in, num};
                m_shadow  <= {dp_in, num};
                m_pending <= 1'b0;
            end else if (load) begin
                m_shadow  <= {dp_in, num};
                m_pending <= 1'b1;
            end else if ((m_cnt % FRAME) == FRAME - 1 && m_pending) begin
                m_active  <= m_shadow;
                m_pending <= 1'b0;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        checks++;
        if ({frame, an, seg, dp_out} !== m_exp) begin
            failures++;
            $display("[TB] FAIL model cnt=%0d: got frame=%b an=%h seg=%h dp=%b, want frame=%b an=%h seg=%h dp=%b",
                     m_cnt, frame, an, seg, dp_out, m_exp[12], m_exp[11:8], m_exp[7:1], m_exp[0]);
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] ea, input logic [6:0] es,
                               input logic ed, input logic ef);
        checks++;
        if (an !== ea || seg !== es || dp_out !== ed || frame !== ef) begin
            failures++;
            $display("[TB] FAIL %s: got an=%h seg=%h dp=%b frame=%b, want an=%h seg=%h dp=%b frame=%b",
                     name, an, seg, dp_out, frame, ea, es, ed, ef);
        end
    endtask

    // Drive inputs; a load is held for exactly one sampling edge.
    task automatic applyStimulus(input logic ld, input logic [15:0] n, input logic [3:0] d,
                                 input logic bl, input logic [BB-1:0] br);
        num    = n;
        dp_in  = d;
        blank  = bl;
        bright = br;
        load   = ld;
        if (ld) begin
            @(posedge clk);
            #2 load = 1'b0;
        end
    endtask

    // Wait until inputs driven now are sampled by the edge of output cycle x.
    task automatic driveAt(input int x);
        int guard = 0;
        while (m_cnt != x && guard < 1000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (m_cnt != x) begin
            checks++;
            failures++;
            $display("[TB] FAIL driveAt timeout: cnt=%0d want %0d", m_cnt, x);
        end
    endtask

    // Literal check of output cycle k.
    task automatic checkAt(input int k, input string name, input logic [3:0] ea,
                           input logic [6:0] es, input logic ed, input logic ef);
        int guard = 0;
        while (m_cnt != k + 1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        checkOutput(name, ea, es, ed, ef);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 2'd3);
        repeat (3) @(posedge clk);
        #3 checkOutput("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        checkAt(0, "first_cycle", 4'hE, 7'h40, 1'b1, 1'b1);

        // Scan order of 0x1234, shown from the frame after the load.
        driveAt(5);
        applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 2'd3);
        checkAt(64, "scan_d0", 4'hE, 7'h19, 1'b1, 1'b1);
        checkAt(80, "scan_d1", 4'hD, 7'h30, 1'b1, 1'b0);
        checkAt(96, "scan_d2", 4'hB, 7'h24, 1'b1, 1'b0);
        checkAt(112, "scan_d3", 4'h7, 7'h79, 1'b1, 1'b0);
        checkAt(128, "frame2", 4'hE, 7'h19, 1'b1, 1'b1);

        // Mid-frame load stays hidden until the next frame.
        driveAt(163);
        applyStimulus(1'b1, 16'hABCD, 4'h0, 1'b0, 2'd3);
        checkAt(176, "tear_old", 4'h7, 7'h79, 1'b1, 1'b0);
        checkAt(192, "tear_new_d0", 4'hE, 7'h21, 1'b1, 1'b1);
        checkAt(208, "tear_new_d1", 4'hD, 7'h46, 1'b1, 1'b0);
        checkAt(240, "tear_new_d3", 4'h7, 7'h08, 1'b1, 1'b0);

        // Load exactly on the wrap cycle shows from digit 0 of the new frame.
        driveAt(255);
        applyStimulus(1'b1, 16'h5678, 4'h0, 1'b0, 2'd3);
        checkAt(256, "wrap_load", 4'hE, 7'h00, 1'b1, 1'b1);

        // Leading-zero blanking.
        driveAt(260);
        applyStimulus(1'b1, 16'h0050, 4'h0, 1'b1, 2'd3);
        checkAt(320, "lz_d0", 4'hE, 7'h40, 1'b1, 1'b1);
        checkAt(336, "lz_d1", 4'hD, 7'h12, 1'b1, 1'b0);
        checkAt(352, "lz_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
        checkAt(368, "lz_d3", 4'hF, 7'h7F, 1'b1, 1'b0);
        driveAt(390);
        applyStimulus(1'b1, 16'h0000, 4'h0, 1'b1, 2'd3);
        checkAt(448, "lz_zero_d0", 4'hE, 7'h40, 1'b1, 1'b1);
        checkAt(464, "lz_zero_d1", 4'hF, 7'h7F, 1'b1, 1'b0);

        // Brightness PWM within a slot.
        driveAt(470);
        applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 2'd0);
        checkAt(512, "br0_c0", 4'hE, 7'h19, 1'b1, 1'b1);
        checkAt(515, "br0_c3", 4'hE, 7'h19, 1'b1, 1'b0);
        checkAt(516, "br0_c4", 4'hF, 7'h7F, 1'b1, 1'b0);
        checkAt(527, "br0_c15", 4'hF, 7'h7F, 1'b1, 1'b0);
        driveAt(528);
        applyStimulus(1'b0, 16'h1234, 4'h0, 1'b0, 2'd2);
        checkAt(539, "br2_c11", 4'hD, 7'h30, 1'b1, 1'b0);
        checkAt(540, "br2_c12", 4'hF, 7'h7F, 1'b1, 1'b0);

        // Decimal point on digit 2 only.
        driveAt(550);
        applyStimulus(1'b1, 16'h1234, 4'b0100, 1'b0, 2'd3);
        checkAt(592, "dp_d1", 4'hD, 7'h30, 1'b1, 1'b0);
        checkAt(608, "dp_d2", 4'hB, 7'h24, 1'b0, 1'b0);
        checkAt(624, "dp_d3", 4'h7, 7'h79, 1'b1, 1'b0);

        // Asynchronous reset mid-frame discards a pending load.
        driveAt(650);
        applyStimulus(1'b1, 16'h9999, 4'hF, 1'b0, 2'd3);
        driveAt(660);
        rst = 1'b1;
        #1 checkOutput("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        checkAt(0, "post_reset", 4'hE, 7'h40, 1'b1, 1'b1);
        checkAt(64, "pending_lost", 4'hE, 7'h40, 1'b1, 1'b1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
